dma_controller: RTL and testbench

DMA_CONTROLLER -- requirements
Module: dma_controller

---
 rtl/dma_controller_pkg.sv | 16 +
 rtl/dma_controller.sv | 103 ++++++++++
 tb/tb_dma_controller.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/dma_controller_pkg.sv
// Shared sizes and FSM state encoding for the block-transfer DMA controller.
package dma_controller_pkg;

  localparam int WORD_SIZE       = 16;
  localparam int BLOCK_SIZE      = 64;
  localparam int WORDS_PER_BLOCK = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WRITE = 3'd2,
    NEXT  = 3'd3,
    DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/dma_controller.sv
// Moves NUM_BLOCKS device blocks to consecutive memory block addresses, arbitrating
// for the bus with BR/BG and raising an interrupt when the whole command is done.
module dma_controller #(
  parameter int WORD_SIZE  = dma_controller_pkg::WORD_SIZE,
  parameter int BLOCK_SIZE = dma_controller_pkg::BLOCK_SIZE,
  parameter int NUM_BLOCKS = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  input  logic [WORD_SIZE-1:0]  cmd_addr,
  output logic                  BR,
  input  logic                  BG,
  input  logic [BLOCK_SIZE-1:0] dev_data,
  output logic                  dev_rd,
  output logic                  mem_write,
  output logic [WORD_SIZE-1:0]  mem_addr,
  output logic [BLOCK_SIZE-1:0] mem_data,
  input  logic                  mem_ready,
  output logic                  dma_end_interrupt,
  output logic                  busy
);
  import dma_controller_pkg::*;

  localparam int               CNT_W    = $clog2(NUM_BLOCKS + 1);
  localparam int               LANE_W   = BLOCK_SIZE / WORDS_PER_BLOCK;
  localparam logic [CNT_W-1:0] LAST_BLK = CNT_W'(NUM_BLOCKS - 1);

  state_t               state_reg, state_next;
  logic [WORD_SIZE-1:0] base_reg, base_next;
  logic [CNT_W-1:0]     blk_cnt_reg, blk_cnt_next;
  logic                 br_reg, mem_write_reg, dev_rd_reg, irq_reg;
  logic [WORD_SIZE-1:0] blk_offset;

  // Strobes are registered from the next state so they line up with state_reg
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      base_reg      <= '0;
      blk_cnt_reg   <= '0;
      br_reg        <= 1'b0;
      mem_write_reg <= 1'b0;
      dev_rd_reg    <= 1'b0;
      irq_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      base_reg      <= base_next;
      blk_cnt_reg   <= blk_cnt_next;
      br_reg        <= (state_next == REQ) || (state_next == WRITE) || (state_next == NEXT);
      mem_write_reg <= (state_next == WRITE);
      dev_rd_reg    <= (state_next == NEXT);
      irq_reg       <= (state_next == DONE);
    end
  end

  always_comb begin
    state_next   = state_reg;
    base_next    = base_reg;
    blk_cnt_next = blk_cnt_reg;
    case (state_reg)
      IDLE: begin
        if (cmd_valid) begin
          base_next    = cmd_addr;
          blk_cnt_next = '0;
          state_next   = REQ;
        end
      end
      REQ: begin
        if (BG) state_next = WRITE;
      end
      WRITE: begin
        // A write accepted in the same cycle the grant drops still counts
        if (mem_ready)  state_next = NEXT;
        else if (!BG)   state_next = REQ;
      end
      NEXT: begin
        blk_cnt_next = blk_cnt_reg + CNT_W'(1);
        state_next   = (blk_cnt_reg == LAST_BLK) ? DONE : WRITE;
      end
      DONE: begin
        if (!BG) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign blk_offset = WORD_SIZE'(blk_cnt_reg) * WORD_SIZE'(WORDS_PER_BLOCK);
  assign mem_addr   = mem_write_reg ? (base_reg + blk_offset) : '0;

  genvar gi;
  generate
    for (gi = 0; gi < WORDS_PER_BLOCK; gi++) begin : g_lane
      assign mem_data[gi*LANE_W +: LANE_W] = mem_write_reg ? dev_data[gi*LANE_W +: LANE_W] : '0;
    end
  endgenerate

  assign BR                = br_reg;
  assign mem_write         = mem_write_reg;
  assign dev_rd            = dev_rd_reg;
  assign dma_end_interrupt = irq_reg;
  assign busy              = (state_reg != IDLE);

endmodule

// File: tb/tb_dma_controller.sv
// Bench for dma_controller: scenario table, random transfers against an address/data
// model, and reset corner sequences.
module tb_dma_controller;

  localparam int NB = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic [15:0] cmd_addr;
  logic        BR, BG, dev_rd, mem_write, mem_ready, dma_end_interrupt, busy;
  logic [15:0] mem_addr;
  logic [63:0] dev_data, mem_data;

  int vectors     = 0;
  int miscompares = 0;

  dma_controller #(.WORD_SIZE(16), .BLOCK_SIZE(64), .NUM_BLOCKS(NB)) dut (
    .clk               (clk),
    .reset             (reset),
    .cmd_valid         (cmd_valid),
    .cmd_addr          (cmd_addr),
    .BR                (BR),
    .BG                (BG),
    .dev_data          (dev_data),
    .dev_rd            (dev_rd),
    .mem_write         (mem_write),
    .mem_addr          (mem_addr),
    .mem_data          (mem_data),
    .mem_ready         (mem_ready),
    .dma_end_interrupt (dma_end_interrupt),
    .busy              (busy)
  );

  always #5 clk = ~clk;

  // Device: block content is a seeded pattern of how many blocks it has handed out
  int unsigned dev_cnt  = 0;
  logic [63:0] dev_seed = 64'h0;
  always @(posedge clk) if (dev_rd) dev_cnt <= dev_cnt + 1;

  function automatic logic [63:0] blk_pattern(input int unsigned idx, input logic [63:0] seed);
    logic [15:0] tag;
    tag = idx[15:0];
    return seed ^ {tag, ~tag, tag ^ 16'hA5A5, tag + 16'd7};
  endfunction

  assign dev_data = blk_pattern(dev_cnt, dev_seed);

  // Block k of a command lands at base + 4k words, modulo 64K
  function automatic logic [15:0] model_addr(input logic [15:0] base, input int k);
    int unsigned a;
    a = (32'(base) + 32'(4 * k)) % 65536;
    return a[15:0];
  endfunction

  typedef struct {
    logic [15:0]      addr;
    int               gdelay;
    int               rdelay;
    int               revoke_blk;
    bit               coincide;
    bit               extra_cmd;
    logic [2:0][15:0] exp_addr;
    int               exp_attempts;
  } vec_t;

  function automatic vec_t mk(input logic [15:0] addr, input int gd, input int rd, input int rb,
                              input bit co, input bit ec, input logic [15:0] a0,
                              input logic [15:0] a1, input logic [15:0] a2, input int att);
    vec_t v;
    v.addr = addr; v.gdelay = gd; v.rdelay = rd; v.revoke_blk = rb;
    v.coincide = co; v.extra_cmd = ec;
    v.exp_addr[0] = a0; v.exp_addr[1] = a1; v.exp_addr[2] = a2;
    v.exp_attempts = att;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  logic [15:0] wr_addr[$];
  logic [63:0] wr_data[$];
  int          attempts, rd_pulses, irq_cycles;
  int          xfer_no = 0;

  // Acts as CPU (grant), memory (ready) and monitor for one whole command
  task automatic run_transfer(input vec_t v);
    int gwait = 0, wcyc = 0, hold = 0, nwr = 0;
    bit started = 0, finished = 0, revoked = 0, coin = 0, extra_sent = 0, prev_revoke = 0;
    bit prev_mw = 0, prev_rd = 0, prev_irq = 0, prev_req = 0, prev_bg = 0;
    logic [15:0] prev_addr = '0;
    logic [63:0] prev_data = '0;
    logic [15:0] got_a;
    logic [63:0] got_d;
    int unsigned start_cnt;
    wr_addr.delete();
    wr_data.delete();
    attempts = 0; rd_pulses = 0; irq_cycles = 0;
    @(negedge clk);
    dev_seed  = {$urandom, $urandom};
    start_cnt = dev_cnt;
    cmd_addr  = v.addr;
    cmd_valid = 1'b1;
    for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      if (busy) started = 1;
      if (prev_req && prev_bg) check("grant_to_write", 64'(mem_write), 64'(1));
      if (prev_rd && nwr < NB) check("next_to_write", 64'(mem_write), 64'(1));
      if (prev_revoke) check("revoke_drops_write", 64'(mem_write), 64'(0));
      if (mem_write && !prev_mw) attempts++;
      if (mem_write && prev_mw) begin
        check("hold_addr", 64'(mem_addr), 64'(prev_addr));
        check("hold_data", mem_data, prev_data);
      end
      if (!mem_write) begin
        check("addr_zero_outside_write", 64'(mem_addr), 64'(0));
        check("data_zero_outside_write", mem_data, 64'(0));
      end
      if (dev_rd) begin
        rd_pulses++;
        check("dev_rd_one_cycle", 64'(prev_rd), 64'(0));
      end
      if (dma_end_interrupt) begin
        irq_cycles++;
        check("done_br_low", 64'(BR), 64'(0));
      end
      if (prev_irq && !dma_end_interrupt) check("irq_held_until_bg_low", 64'(prev_bg), 64'(0));

      prev_revoke = 0;
      mem_ready   = 1'b0;
      if (v.extra_cmd && mem_write && !extra_sent) begin
        cmd_valid  = 1'b1;
        cmd_addr   = 16'h0100;
        extra_sent = 1;
      end
      if (started && !busy) begin
        finished = 1;
        BG       = 1'b0;
      end else if (dma_end_interrupt) begin
        if (irq_cycles >= 2) BG = 1'b0;
      end else if (hold > 0) begin
        hold--;
        if (hold == 0) BG = 1'b1;
      end else if (mem_write) begin
        wcyc++;
        if (v.revoke_blk == nwr && !revoked) begin
          BG = 1'b0; revoked = 1; prev_revoke = 1; hold = 3; wcyc = 0;
        end else if (wcyc > v.rdelay) begin
          mem_ready = 1'b1;
          wcyc      = 0;
          wr_addr.push_back(mem_addr);
          wr_data.push_back(mem_data);
          nwr++;
          if (v.coincide && nwr == NB) begin
            BG   = 1'b0;
            coin = 1;
          end
        end
      end else if (BR && !BG && !dev_rd && !coin) begin
        gwait++;
        if (gwait >= v.gdelay) begin
          BG    = 1'b1;
          gwait = 0;
        end
      end
      prev_mw   = mem_write;
      prev_addr = mem_addr;
      prev_data = mem_data;
      prev_rd   = dev_rd;
      prev_irq  = dma_end_interrupt;
      prev_req  = BR && !mem_write && !dev_rd;
      prev_bg   = BG;
    end
    BG = 1'b0; mem_ready = 1'b0; cmd_valid = 1'b0;

    check("xfer_terminates", 64'(finished), 64'(1));
    check("write_count", 64'(wr_addr.size()), 64'(NB));
    check("write_attempts", 64'(attempts), 64'(v.exp_attempts));
    check("dev_rd_pulses", 64'(rd_pulses), 64'(NB));
    check("irq_asserted", 64'(irq_cycles > 0), 64'(1));
    for (int k = 0; k < NB; k++) begin
      got_a = (k < wr_addr.size()) ? wr_addr[k] : 16'hxxxx;
      got_d = (k < wr_data.size()) ? wr_data[k] : 64'hx;
      check("write_addr", 64'(got_a), 64'(v.exp_addr[k]));
      check("write_data", got_d, blk_pattern(start_cnt + 32'(k), dev_seed));
    end
    $display("xfer %0d base=%04h gdly=%0d rdly=%0d revoke_blk=%0d coincide=%0d extra_cmd=%0d writes=%0d attempts=%0d irq_cycles=%0d",
             xfer_no, v.addr, v.gdelay, v.rdelay, v.revoke_blk, v.coincide, v.extra_cmd,
             wr_addr.size(), attempts, irq_cycles);
    xfer_no++;
  endtask

  initial begin
    vec_t        tbl[6];
    vec_t        rv;
    logic [15:0] a;
    int          rb;
    int          n;

    reset = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; BG = 1'b0; mem_ready = 1'b0;

    tbl[0] = mk(16'h0017, 2, 1, -1, 0, 0, 16'h0017, 16'h001B, 16'h001F, 3); // nominal
    tbl[1] = mk(16'h0017, 2, 1,  1, 0, 0, 16'h0017, 16'h001B, 16'h001F, 4); // grant revoked on block 1
    tbl[2] = mk(16'hFFF8, 2, 1, -1, 0, 0, 16'hFFF8, 16'hFFFC, 16'h0000, 3); // address wrap
    tbl[3] = mk(16'h0017, 2, 1, -1, 0, 1, 16'h0017, 16'h001B, 16'h001F, 3); // command while busy
    tbl[4] = mk(16'h0017, 2, 1, -1, 1, 0, 16'h0017, 16'h001B, 16'h001F, 3); // ready + BG fall together
    tbl[5] = mk(16'h1230, 0, 3,  0, 0, 0, 16'h1230, 16'h1234, 16'h1238, 4); // revoke first block, slow memory

    repeat (2) @(negedge clk);
    check("rst_BR", 64'(BR), 64'(0));
    check("rst_mem_write", 64'(mem_write), 64'(0));
    check("rst_mem_addr", 64'(mem_addr), 64'(0));
    check("rst_mem_data", mem_data, 64'(0));
    check("rst_dev_rd", 64'(dev_rd), 64'(0));
    check("rst_irq", 64'(dma_end_interrupt), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    reset = 1'b0;

    for (int i = 0; i < 6; i++) run_transfer(tbl[i]);

    for (int i = 0; i < 8; i++) begin
      a  = (i % 3 == 0) ? (16'hFFF0 | 16'($urandom_range(0, 15))) : 16'($urandom);
      rb = int'($urandom_range(0, 4)) - 1;
      rv = mk(a, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), rb,
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              model_addr(a, 0), model_addr(a, 1), model_addr(a, 2),
              NB + ((rb >= 0 && rb < NB) ? 1 : 0));
      run_transfer(rv);
    end

    // Reset while a block write is outstanding: everything drops at once, nothing follows
    @(negedge clk);
    cmd_addr  = 16'h0040;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    BG        = 1'b1;
    n = 0;
    while (!mem_write && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("midrst_reached_write", 64'(mem_write), 64'(1));
    reset = 1'b1;
    #1;
    check("midrst_BR", 64'(BR), 64'(0));
    check("midrst_mem_write", 64'(mem_write), 64'(0));
    check("midrst_busy", 64'(busy), 64'(0));
    check("midrst_mem_addr", 64'(mem_addr), 64'(0));
    @(negedge clk);
    reset     = 1'b0;
    mem_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      check("midrst_no_write", 64'(mem_write), 64'(0));
      check("midrst_no_irq", 64'(dma_end_interrupt), 64'(0));
      check("midrst_idle", 64'(busy), 64'(0));
    end
    BG        = 1'b0;
    mem_ready = 1'b0;
    $display("xfer %0d reset mid-write base=0040", xfer_no);
    xfer_no++;

    run_transfer(tbl[0]);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
